lt24_pixel_port: RTL and testbench
==================================

# lt24_pixel_port

Responder side of the pixel write interface used by the game drawing logic. It accepts `xAddr`/`yAddr`/`pixelData` transfers through a `pixelWrite`/`pixelReady` handshake and converts them into 8080-style 16-bit write cycles on the LT24 panel bus. When a pixel does not follow on from the previous one, the block first re-sends the column, page and memory-write command window. Panel power-up and initialisation are handled by a separate init block, which signals completion on `initDone`; this block owns the bus only after that.

## Interface
Parameters:
- `WIDTH`, 240, panel columns; x range 0..WIDTH-1
- `HEIGHT`, 320, panel rows; y range 0..HEIGHT-1
- `WR_LOW_CYCLES`, 1, clocks `LT24Wr_n` is held low per bus word (≥1)
- `WR_HIGH_CYCLES`, 1, clocks `LT24Wr_n` is held high per bus word (≥1)

Ports:
- `clock`  in  1  single system clock
- `reset`  in  1  asynchronous, active-high reset
- `initDone`  in  1  high while the panel is initialised and the bus is granted to this block
- `xAddr`  in  8  pixel column
- `yAddr`  in  9  pixel row
- `pixelData`  in  16  RGB565 colour
- `pixelWrite`  in  1  requester has a valid pixel
- `pixelReady`  out  1  block can accept a pixel this cycle
- `LT24Wr_n`  out  1  write strobe, active low; the panel latches on the rising edge
- `LT24Rd_n`  out  1  read strobe; held at 1
- `LT24CS_n`  out  1  chip select, active low
- `LT24RS`  out  1  0 = command word, 1 = data word
- `LT24Data`  out  16  bus data

## Operation
- **Handshake.** A transfer occurs on a clock edge where `pixelWrite && pixelReady`. The block captures x, y and data on that edge and drops `pixelReady` on the next cycle.
- **States.** IDLE, WINDOW, DATA.
- **IDLE:**
  - `pixelReady` = `initDone`.
  - On a transfer:
    - If the address is out of range (x ≥ WIDTH or y ≥ HEIGHT), the pixel is dropped with no bus activity and the state stays IDLE. `pixelReady` is low for 1 cycle.
    - Else if `sessionOpen` is set and (x,y) equals `expected`, go to DATA.
    - Else go to WINDOW with `seqIdx` = 0.
- **WINDOW.** Sends 11 words in order, indexed by `seqIdx`:
  - cmd 0x2A
  - data `x[15:8]`, `x[7:0]`, `(WIDTH-1)[15:8]`, `(WIDTH-1)[7:0]`
  - cmd 0x2B
  - data `y[15:8]`, `y[7:0]`, `(HEIGHT-1)[15:8]`, `(HEIGHT-1)[7:0]`
  - cmd 0x2C
  - Byte values are zero-extended onto `LT24Data[7:0]`, upper bits 0.
  - After the last word: set `sessionOpen`, go to DATA.
- **DATA.** Sends one data word carrying the pixel, then:
  - updates `expected` to x+1, y;
  - if x = WIDTH-1, `expected` is 0, y+1;
  - if additionally y = HEIGHT-1, `expected` is (0,0);
  - returns to IDLE.
- **Bus word.**
  - `LT24RS` and `LT24Data` are driven in the first low cycle and held stable through all low and high cycles.
  - `LT24CS_n` is 0 for the entire word sequence and returns to 1 in IDLE.
- **`initDone` falling mid-operation.** The current word completes, the remaining sequence is abandoned, `sessionOpen` is cleared, and the state returns to IDLE with `pixelReady` 0.
- **Out-of-range pixels** leave `sessionOpen` and `expected` unchanged.

## Timing
- **Reset values.** `pixelReady`=0, `LT24Wr_n`=1, `LT24Rd_n`=1, `LT24CS_n`=1, `LT24RS`=1, `LT24Data`=0, state IDLE, `sessionOpen`=0, `expected`=(0,0).
- **Reset mid-word.** The async reset forces the reset values immediately. The next pixel always resends the window.
- **Word length.** One bus word takes W = WR_LOW_CYCLES + WR_HIGH_CYCLES cycles.
- **Sequential pixel.** Accept at edge N; `LT24Wr_n` low from cycle N+1; `pixelReady` high again at cycle N+1+W. The defaults give one pixel per 3 cycles.
- **Non-sequential pixel.** Takes 12·W + 1 cycles, i.e. 25 with the defaults.
- **Outputs** are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `lt24_pkg`** holds:
  - command constants `CMD_CASET`=0x2A, `CMD_PASET`=0x2B, `CMD_RAMWR`=0x2C;
  - the state encoding;
  - the window sequence length (11).
- **Sub-module `lt24_bus_write`:**
  - Generates one word strobe from inputs `start`, `rs`, `data`.
  - Drives `Wr_n`/`RS`/`Data` and pulses `done` in the last high cycle.
  - Parameterised by `WR_LOW_CYCLES` and `WR_HIGH_CYCLES`.
- **Top level** owns the FSM, `seqIdx`, the capture registers and the `expected`/`sessionOpen` tracking.

## Test plan
- **First pixel after reset:** with `initDone`=1, write (10,20,0xF800).
  - Bus shows 0x2A(RS0), 0,10,0,239 (RS1), 0x2B(RS0), 0,20,1,63 (RS1), 0x2C(RS0), 0xF800(RS1).
  - `pixelReady` returns after 25 cycles.
- **Sequential and non-sequential follow-on:**
  - Write (11,20,0x07E0) next: a single data word 0x07E0, no commands, ready after 3 cycles.
  - Then write (50,20): the full 11-word window is resent.
- **Row and frame wrap:**
  - Write (239,5) then (0,6): the second pixel is data-only.
  - Write (239,319) then (0,0): the second pixel is data-only.
- **Out-of-range pixel:** write (240,0).
  - No `LT24Wr_n` activity, `pixelReady` low for 1 cycle.
  - The next in-sequence pixel is still data-only.
- **`initDone` low:**
  - With `initDone`=0, `pixelReady` stays 0 and `pixelWrite` is ignored.
  - Dropping `initDone` during WINDOW word 4 completes that word, then IDLE. The next pixel resends the full window.
- **Reset during a DATA word:**
  - Assert `reset` while `LT24Wr_n`=0: `LT24Wr_n` and `LT24CS_n` go to 1 immediately, without waiting for a clock edge.
  - After release, a write to the previously expected address resends the window.

Source files
------------

// File: rtl/lt24_pkg.sv
// Shared constants and state encoding for the LT24 pixel write port.
package lt24_pkg;

    localparam logic [15:0] CMD_CASET = 16'h002A;
    localparam logic [15:0] CMD_PASET = 16'h002B;
    localparam logic [15:0] CMD_RAMWR = 16'h002C;

    localparam int WIN_LEN = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_DATA
    } state_e;

endpackage

// File: rtl/lt24_bus_write.sv
// One 8080-style write word: strobe low then high, with RS/data held for the whole word.
module lt24_bus_write #(
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        rs_i,
    input  logic [15:0] data_i,
    output logic        wr_n_o,
    output logic        rs_o,
    output logic [15:0] data_o,
    output logic        done_o
);

    localparam int MAXC  = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CNT_W = $clog2(MAXC) + 1;

    logic             busy_q;
    logic             high_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_n_q;
    logic             rs_q;
    logic [15:0]      data_q;

    // A new start may coincide with done so consecutive words run back to back.
    assign done_o = busy_q && high_q && (cnt_q == CNT_W'(WR_HIGH_CYCLES - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            cnt_q  <= '0;
            wr_n_q <= 1'b1;
            rs_q   <= 1'b1;
            data_q <= 16'h0000;
        end else if (start_i) begin
            busy_q <= 1'b1;
            high_q <= 1'b0;
            cnt_q  <= '0;
            wr_n_q <= 1'b0;
            rs_q   <= rs_i;
            data_q <= data_i;
        end else if (busy_q) begin
            if (!high_q) begin
                if (cnt_q == CNT_W'(WR_LOW_CYCLES - 1)) begin
                    high_q <= 1'b1;
                    cnt_q  <= '0;
                    wr_n_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign wr_n_o = wr_n_q;
    assign rs_o   = rs_q;
    assign data_o = data_q;

endmodule

// File: rtl/lt24_pixel_port.sv
// Pixel write responder: turns handshaked pixels into LT24 bus words, resending the
// column/page/RAM-write window whenever a pixel does not follow on from the last one.
module lt24_pixel_port
    import lt24_pkg::*;
#(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        initDone,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    state_e      state_q;
    logic [3:0]  seq_q;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [15:0] pix_q;
    logic        session_q;
    logic [7:0]  exp_x_q;
    logic [8:0]  exp_y_q;
    logic        ready_q;
    logic        cs_n_q;

    logic        xfer;
    logic        in_range;
    logic        hit;
    logic        bus_start;
    logic        bus_rs;
    logic [15:0] bus_data;
    logic        bus_done;

    // Word idx of the window sequence as {rs, data}.
    function automatic logic [16:0] win_word(input logic [3:0] idx, input logic [7:0] x,
                                             input logic [8:0] y);
        logic [15:0] xw;
        logic [15:0] yw;
        xw = {8'h00, x};
        yw = {7'h00, y};
        case (idx)
            4'd0:    return {1'b0, CMD_CASET};
            4'd1:    return {1'b1, 8'h00, xw[15:8]};
            4'd2:    return {1'b1, 8'h00, xw[7:0]};
            4'd3:    return {1'b1, 8'h00, X_LAST[15:8]};
            4'd4:    return {1'b1, 8'h00, X_LAST[7:0]};
            4'd5:    return {1'b0, CMD_PASET};
            4'd6:    return {1'b1, 8'h00, yw[15:8]};
            4'd7:    return {1'b1, 8'h00, yw[7:0]};
            4'd8:    return {1'b1, 8'h00, Y_LAST[15:8]};
            4'd9:    return {1'b1, 8'h00, Y_LAST[7:0]};
            default: return {1'b0, CMD_RAMWR};
        endcase
    endfunction

    assign xfer     = pixelWrite && ready_q;
    assign in_range = ({8'h00, xAddr} <= X_LAST) && ({7'h00, yAddr} <= Y_LAST);
    assign hit      = session_q && (xAddr == exp_x_q) && (yAddr == exp_y_q);

    // The first word of a sequence starts on the accepting edge, so it is chosen from the inputs.
    always_comb begin
        bus_start = 1'b0;
        bus_rs    = 1'b1;
        bus_data  = pix_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && initDone && in_range) begin
                    bus_start = 1'b1;
                    if (hit) {bus_rs, bus_data} = {1'b1, pixelData};
                    else     {bus_rs, bus_data} = win_word(4'd0, xAddr, yAddr);
                end
            end
            ST_WINDOW: begin
                if (bus_done && initDone) begin
                    bus_start = 1'b1;
                    if (seq_q == 4'(WIN_LEN - 1)) {bus_rs, bus_data} = {1'b1, pix_q};
                    else                          {bus_rs, bus_data} = win_word(seq_q + 4'd1, x_q, y_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            seq_q     <= 4'd0;
            x_q       <= 8'h00;
            y_q       <= 9'h000;
            pix_q     <= 16'h0000;
            session_q <= 1'b0;
            exp_x_q   <= 8'h00;
            exp_y_q   <= 9'h000;
            ready_q   <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        ready_q <= 1'b0;
                        x_q     <= xAddr;
                        y_q     <= yAddr;
                        pix_q   <= pixelData;
                        if (initDone && in_range) begin
                            cs_n_q <= 1'b0;
                            if (hit) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_WINDOW;
                                seq_q   <= 4'd0;
                            end
                        end
                    end else begin
                        ready_q <= initDone;
                    end
                end
                ST_WINDOW: begin
                    if (bus_done) begin
                        if (!initDone) begin
                            state_q   <= ST_IDLE;
                            cs_n_q    <= 1'b1;
                            session_q <= 1'b0;
                        end else if (seq_q == 4'(WIN_LEN - 1)) begin
                            session_q <= 1'b1;
                            state_q   <= ST_DATA;
                        end else begin
                            seq_q <= seq_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus_done) begin
                        if ({8'h00, x_q} == X_LAST) begin
                            exp_x_q <= 8'h00;
                            exp_y_q <= ({7'h00, y_q} == Y_LAST) ? 9'h000 : y_q + 9'd1;
                        end else begin
                            exp_x_q <= x_q + 8'd1;
                            exp_y_q <= y_q;
                        end
                        if (!initDone) session_q <= 1'b0;
                        state_q <= ST_IDLE;
                        cs_n_q  <= 1'b1;
                        ready_q <= initDone;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    lt24_bus_write #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_bus (
        .clock_i(clock),
        .reset_i(reset),
        .start_i(bus_start),
        .rs_i   (bus_rs),
        .data_i (bus_data),
        .wr_n_o (LT24Wr_n),
        .rs_o   (LT24RS),
        .data_o (LT24Data),
        .done_o (bus_done)
    );

    assign pixelReady = ready_q;
    assign LT24CS_n   = cs_n_q;
    assign LT24Rd_n   = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_port.sv
// Directed bench for lt24_pixel_port: bus words, handshake latency, session tracking.
module tb_lt24_pixel_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        initDone;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        LT24Wr_n;
    logic        LT24Rd_n;
    logic        LT24CS_n;
    logic        LT24RS;
    logic [15:0] LT24Data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_falls = 0;
    logic [16:0] bus_q[$];
    logic [16:0] exp_q[$];

    always #5 clock = ~clock;

    lt24_pixel_port dut (
        .clock     (clock),
        .reset     (reset),
        .initDone  (initDone),
        .xAddr     (xAddr),
        .yAddr     (yAddr),
        .pixelData (pixelData),
        .pixelWrite(pixelWrite),
        .pixelReady(pixelReady),
        .LT24Wr_n  (LT24Wr_n),
        .LT24Rd_n  (LT24Rd_n),
        .LT24CS_n  (LT24CS_n),
        .LT24RS    (LT24RS),
        .LT24Data  (LT24Data)
    );

    // Panel latches on the rising strobe edge.
    always @(posedge LT24Wr_n) if (!reset) bus_q.push_back({LT24RS, LT24Data});
    always @(negedge LT24Wr_n) wr_falls++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_window(input logic [7:0] x, input logic [8:0] y);
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({1'b1, 16'd0});
        exp_q.push_back({1'b1, 8'd0, x});
        exp_q.push_back({1'b1, 16'd0});
        exp_q.push_back({1'b1, 16'd239});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({1'b1, 15'd0, y[8]});
        exp_q.push_back({1'b1, 8'd0, y[7:0]});
        exp_q.push_back({1'b1, 16'd1});
        exp_q.push_back({1'b1, 16'd63});
        exp_q.push_back({1'b0, 16'h002C});
    endtask

    task automatic cmp_bus(input string tag);
        check($sformatf("%s_words", tag), 32'(bus_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(bus_q[i]), 32'(exp_q[i]));
        bus_q.delete();
        exp_q.delete();
    endtask

    task automatic start_pixel(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        int g;
        g = 0;
        while (!pixelReady && g < 100) begin
            @(negedge clock);
            g++;
        end
        check("ready_before_write", 32'(pixelReady), 32'd1);
        xAddr      = x;
        yAddr      = y;
        pixelData  = d;
        pixelWrite = 1'b1;
        @(posedge clock);
        #1 pixelWrite = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                        output int lat);
        start_pixel(x, y, d);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!pixelReady && lat < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int falls;
        reset      = 1'b1;
        initDone   = 1'b0;
        pixelWrite = 1'b0;
        xAddr      = 8'd0;
        yAddr      = 9'd0;
        pixelData  = 16'h0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(pixelReady), 32'd0);
        check("rst_wr_n",  32'(LT24Wr_n),   32'd1);
        check("rst_rd_n",  32'(LT24Rd_n),   32'd1);
        check("rst_cs_n",  32'(LT24CS_n),   32'd1);
        check("rst_rs",    32'(LT24RS),     32'd1);
        check("rst_data",  32'(LT24Data),   32'd0);

        // initDone low: no readiness, writes ignored
        reset      = 1'b0;
        pixelWrite = 1'b1;
        xAddr      = 8'd1;
        repeat (5) @(negedge clock);
        check("noinit_ready", 32'(pixelReady), 32'd0);
        check("noinit_falls", 32'(wr_falls),   32'd0);
        check("noinit_cs_n",  32'(LT24CS_n),   32'd1);
        pixelWrite = 1'b0;
        initDone   = 1'b1;
        @(negedge clock);
        check("init_ready", 32'(pixelReady), 32'd1);

        // first pixel: full window
        send(8'd10, 9'd20, 16'hF800, lat);
        check("first_lat", 32'(lat), 32'd25);
        push_window(8'd10, 9'd20);
        exp_q.push_back({1'b1, 16'hF800});
        cmp_bus("first");

        send(8'd11, 9'd20, 16'h07E0, lat);
        check("seq_lat", 32'(lat), 32'd3);
        exp_q.push_back({1'b1, 16'h07E0});
        cmp_bus("seq");

        send(8'd50, 9'd20, 16'h1234, lat);
        check("jump_lat", 32'(lat), 32'd25);
        push_window(8'd50, 9'd20);
        exp_q.push_back({1'b1, 16'h1234});
        cmp_bus("jump");

        // row wrap
        send(8'd239, 9'd5, 16'hAAAA, lat);
        check("row_end_lat", 32'(lat), 32'd25);
        push_window(8'd239, 9'd5);
        exp_q.push_back({1'b1, 16'hAAAA});
        cmp_bus("row_end");
        send(8'd0, 9'd6, 16'h5555, lat);
        check("row_wrap_lat", 32'(lat), 32'd3);
        exp_q.push_back({1'b1, 16'h5555});
        cmp_bus("row_wrap");

        // frame wrap
        send(8'd239, 9'd319, 16'h1111, lat);
        check("frame_end_lat", 32'(lat), 32'd25);
        push_window(8'd239, 9'd319);
        exp_q.push_back({1'b1, 16'h1111});
        cmp_bus("frame_end");
        send(8'd0, 9'd0, 16'h2222, lat);
        check("frame_wrap_lat", 32'(lat), 32'd3);
        exp_q.push_back({1'b1, 16'h2222});
        cmp_bus("frame_wrap");

        // out-of-range pixels are dropped silently
        falls = wr_falls;
        send(8'd240, 9'd0, 16'hBEEF, lat);
        check("oor_x_lat",   32'(lat),      32'd2);
        check("oor_x_falls", 32'(wr_falls), 32'(falls));
        check("oor_x_cs_n",  32'(LT24CS_n), 32'd1);
        cmp_bus("oor_x");
        send(8'd1, 9'd0, 16'h3333, lat);
        check("after_oor_lat", 32'(lat), 32'd3);
        exp_q.push_back({1'b1, 16'h3333});
        cmp_bus("after_oor");
        falls = wr_falls;
        send(8'd5, 9'd320, 16'hCAFE, lat);
        check("oor_y_lat",   32'(lat),      32'd2);
        check("oor_y_falls", 32'(wr_falls), 32'(falls));
        cmp_bus("oor_y");
        send(8'd2, 9'd0, 16'h4444, lat);
        check("after_oor_y_lat", 32'(lat), 32'd3);
        exp_q.push_back({1'b1, 16'h4444});
        cmp_bus("after_oor_y");

        // initDone dropped while window word 4 is on the bus
        start_pixel(8'd100, 9'd100, 16'h6666);
        repeat (8) @(posedge clock);
        #1;
        check("abort_word4_low", 32'(LT24Wr_n),     32'd0);
        check("abort_pre_words", 32'(bus_q.size()), 32'd4);
        initDone = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_ready", 32'(pixelReady), 32'd0);
        check("abort_cs_n",  32'(LT24CS_n),   32'd1);
        push_window(8'd100, 9'd100);
        exp_q = exp_q[0:4];
        cmp_bus("abort");
        initDone = 1'b1;
        send(8'd3, 9'd0, 16'h7777, lat);
        check("after_abort_lat", 32'(lat), 32'd25);
        push_window(8'd3, 9'd0);
        exp_q.push_back({1'b1, 16'h7777});
        cmp_bus("after_abort");

        // async reset in the middle of a data word
        start_pixel(8'd4, 9'd0, 16'h8888);
        check("pre_rst_wr_n", 32'(LT24Wr_n), 32'd0);
        check("pre_rst_cs_n", 32'(LT24CS_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_wr_n",  32'(LT24Wr_n),   32'd1);
        check("async_rst_cs_n",  32'(LT24CS_n),   32'd1);
        check("async_rst_ready", 32'(pixelReady), 32'd0);
        check("async_rst_data",  32'(LT24Data),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        bus_q.delete();
        send(8'd5, 9'd0, 16'h9999, lat);
        check("after_rst_lat", 32'(lat), 32'd25);
        push_window(8'd5, 9'd0);
        exp_q.push_back({1'b1, 16'h9999});
        cmp_bus("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
